// File: rtl/aes_round_sequencer.sv
// AES round sequencer: steps a round datapath through load, Nr-1 middle rounds,
// the final round and result drain, with COLS 32-bit columns per beat.
module aes_round_sequencer #(
    parameter  int COLS  = 1,
    localparam int B     = 4 / COLS,
    localparam int CNT_W = (B > 1) ? $clog2(B) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       key_len,
    input  logic             mode,
    output logic             mode_q,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             key_valid,
    output logic             key_req,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             abort,
    output logic [CNT_W-1:0] count_cycle,
    output logic [3:0]       round_idx,
    output logic             input_round,
    output logic             last_round,
    output logic             done_round,
    output logic             idle_round,
    output logic             round_en,
    output logic             err
);

    if (!(COLS == 1 || COLS == 2 || COLS == 4)) begin : g_bad_cols
        $error("aes_round_sequencer: COLS must be 1, 2 or 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_LAST,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_round;
    logic [3:0]       r_nr;
    logic             r_mode;
    logic             r_err;
    logic             r_idle;
    logic             r_input;
    logic             r_key_req;
    logic             r_last;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_round_nxt;
    logic             w_err_nxt;
    logic             w_beat_last;
    logic             w_key_adv;
    logic             w_out_adv;
    logic             w_abort;
    logic             w_adv;
    logic             w_start;
    logic             w_start_ok;

    // Beat-advance qualification is the only combinational use of the handshakes.
    always_comb begin
        w_key_adv = 1'b0;
        case (r_state)
            S_LOAD:          w_key_adv = din_valid & key_valid;
            S_ROUND, S_LAST: w_key_adv = key_valid;
            default:         w_key_adv = 1'b0;
        endcase
    end

    assign w_beat_last = (r_cnt == CNT_W'(B - 1));
    assign w_out_adv   = (r_state == S_DONE) & out_ready;
    assign w_abort     = abort & (r_state != S_IDLE);
    assign w_adv       = (w_key_adv | w_out_adv) & ~w_abort;
    assign w_start     = (r_state == S_IDLE) & start_valid;
    assign w_start_ok  = w_start & (key_len != 2'd3);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_round_nxt = r_round;
        w_err_nxt   = 1'b0;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_round_nxt = 4'd0;
        end else if (w_start) begin
            if (w_start_ok) begin
                w_state_nxt = S_LOAD;
                w_cnt_nxt   = '0;
                w_round_nxt = 4'd0;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (w_adv) begin
            if (w_beat_last) begin
                w_cnt_nxt = '0;
                case (r_state)
                    S_LOAD: begin
                        w_state_nxt = S_ROUND;
                        w_round_nxt = 4'd1;
                    end
                    S_ROUND: begin
                        w_round_nxt = r_round + 4'd1;
                        if ((r_round + 4'd1) == r_nr) begin
                            w_state_nxt = S_LAST;
                        end
                    end
                    S_LAST: begin
                        w_state_nxt = S_DONE;
                    end
                    S_DONE: begin
                        w_state_nxt = S_IDLE;
                        w_round_nxt = 4'd0;
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_round_nxt = 4'd0;
                    end
                endcase
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Phase strobes are registered from the next state so they are clean flop outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_round   <= 4'd0;
            r_nr      <= 4'd10;
            r_mode    <= 1'b0;
            r_err     <= 1'b0;
            r_idle    <= 1'b1;
            r_input   <= 1'b0;
            r_key_req <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_round   <= w_round_nxt;
            r_err     <= w_err_nxt;
            r_idle    <= (w_state_nxt == S_IDLE);
            r_input   <= (w_state_nxt == S_LOAD);
            r_key_req <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_ROUND) ||
                         (w_state_nxt == S_LAST);
            r_last    <= (w_state_nxt == S_LAST);
            r_done    <= (w_state_nxt == S_DONE);
            if (w_start_ok) begin
                r_nr   <= 4'd10 + {1'b0, key_len, 1'b0};
                r_mode <= mode;
            end
        end
    end

    assign start_ready = r_idle;
    assign idle_round  = r_idle;
    assign input_round = r_input;
    assign din_ready   = r_input;
    assign key_req     = r_key_req;
    assign last_round  = r_last;
    assign done_round  = r_done;
    assign out_valid   = r_done;
    assign count_cycle = r_cnt;
    assign round_idx   = r_round;
    assign mode_q      = r_mode;
    assign err         = r_err;
    assign round_en    = w_key_adv & ~w_abort & ~rst;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: beat-position model of the job plus directed timing probes.
module tb_aes_round_sequencer;
    localparam int B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_valid, mode, din_valid, key_valid, out_ready, abort;
    logic [1:0] key_len;
    logic       start_ready, mode_q, din_ready, key_req, out_valid;
    logic [1:0] count_cycle;
    logic [3:0] round_idx;
    logic       input_round, last_round, done_round, idle_round, round_en, err;

    logic       s4_rst, s4_start_valid, s4_mode, s4_din_valid, s4_key_valid, s4_out_ready, s4_abort;
    logic [1:0] s4_key_len;
    logic       start_ready4, mode_q4, din_ready4, key_req4, out_valid4;
    logic [0:0] count_cycle4;
    logic [3:0] round_idx4;
    logic       input_round4, last_round4, done_round4, idle_round4, round_en4, err4;

    aes_round_sequencer #(.COLS(1)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .key_len(key_len), .mode(mode), .mode_q(mode_q), .din_valid(din_valid),
        .din_ready(din_ready), .key_valid(key_valid), .key_req(key_req),
        .out_valid(out_valid), .out_ready(out_ready), .abort(abort),
        .count_cycle(count_cycle), .round_idx(round_idx), .input_round(input_round),
        .last_round(last_round), .done_round(done_round), .idle_round(idle_round),
        .round_en(round_en), .err(err)
    );

    aes_round_sequencer #(.COLS(4)) dut4 (
        .clk(clk), .rst(s4_rst), .start_valid(s4_start_valid), .start_ready(start_ready4),
        .key_len(s4_key_len), .mode(s4_mode), .mode_q(mode_q4), .din_valid(s4_din_valid),
        .din_ready(din_ready4), .key_valid(s4_key_valid), .key_req(key_req4),
        .out_valid(out_valid4), .out_ready(s4_out_ready), .abort(s4_abort),
        .count_cycle(count_cycle4), .round_idx(round_idx4), .input_round(input_round4),
        .last_round(last_round4), .done_round(done_round4), .idle_round(idle_round4),
        .round_en(round_en4), .err(err4)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a job is a linear run of (Nr+2)*B beats; position p fixes every output.
    int m_busy = 0, m_p = 0, m_nr = 10, m_mode = 0, m_err = 0;

    always @(posedge clk) begin : model
        int  ph;
        bit  adv;
        ph = m_p / B;
        if (ph == 0)          adv = din_valid && key_valid;
        else if (ph <= m_nr)  adv = key_valid;
        else                  adv = out_ready;
        if (rst) begin
            m_busy = 0; m_p = 0; m_mode = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (!m_busy) begin
                if (start_valid) begin
                    if (key_len == 2'd3) m_err = 1;
                    else begin
                        m_busy = 1; m_p = 0; m_nr = 10 + 2 * int'(key_len); m_mode = int'(mode);
                    end
                end
            end else if (abort) begin
                m_busy = 0; m_p = 0;
            end else if (adv) begin
                m_p++;
                if (m_p == (m_nr + 2) * B) begin
                    m_busy = 0; m_p = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        int ph, e_rnd, e_ren;
        if (chk_en) begin
            ph    = m_p / B;
            e_rnd = !m_busy ? 0 : (ph > m_nr ? m_nr : ph);
            e_ren = (m_busy && !rst && !abort && ph <= m_nr &&
                     (ph == 0 ? (din_valid && key_valid) : key_valid)) ? 1 : 0;
            chk("start_ready", start_ready, !m_busy);
            chk("idle_round",  idle_round,  !m_busy);
            chk("input_round", input_round, m_busy && ph == 0);
            chk("din_ready",   din_ready,   m_busy && ph == 0);
            chk("key_req",     key_req,     m_busy && ph <= m_nr);
            chk("last_round",  last_round,  m_busy && ph == m_nr);
            chk("done_round",  done_round,  m_busy && ph == m_nr + 1);
            chk("out_valid",   out_valid,   m_busy && ph == m_nr + 1);
            chk("count_cycle", count_cycle, m_busy ? m_p % B : 0);
            chk("round_idx",   round_idx,   e_rnd);
            chk("mode_q",      mode_q,      m_mode);
            chk("err",         err,         m_err);
            chk("round_en",    round_en,    e_ren);
        end
    end

    // Directed job; n counts edges since the start edge, so after edge n the bench sits in cycle T+n.
    task automatic job(input int kl, input int kv_lo_at, input int or_lo_at, input int abort_at,
                       input int rst_at, input int probe_n,
                       output int t_last, output int t_out, output int t_idle,
                       output int pr_cnt, output int pr_rnd, output int pr_ov, output int pr_err);
        start_valid = 1; key_len = 2'(kl); mode = 1; din_valid = 1; key_valid = 1; out_ready = 1;
        t_last = -1; t_out = -1; t_idle = -1;
        pr_cnt = -1; pr_rnd = -1; pr_ov = -1; pr_err = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            start_valid = 0;
            key_valid = !(kv_lo_at > 0 && n >= kv_lo_at && n < kv_lo_at + 3);
            out_ready = !(or_lo_at > 0 && n >= or_lo_at && n < or_lo_at + 2);
            abort = (n == abort_at);
            rst   = (n == rst_at);
            if (n == probe_n) begin
                pr_cnt = int'(count_cycle); pr_rnd = int'(round_idx);
                pr_ov = int'(out_valid); pr_err = int'(err);
            end
            if (last_round && t_last < 0) t_last = n;
            if (out_valid && t_out < 0) t_out = n;
            if (idle_round) begin
                t_idle = n;
                break;
            end
        end
        abort = 0; rst = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int tl, to, ti, pc, pr, po, pe;
        int en4, dn4, to4, ti4;
        rst = 1; start_valid = 0; key_len = 0; mode = 0; din_valid = 0;
        key_valid = 0; out_ready = 0; abort = 0;
        s4_rst = 1; s4_start_valid = 0; s4_key_len = 0; s4_mode = 0; s4_din_valid = 0;
        s4_key_valid = 0; s4_out_ready = 0; s4_abort = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        chk("rst_round_idx", round_idx, 0);
        chk("rst_idle", idle_round, 1);
        rst = 0; s4_rst = 0;
        @(posedge clk); #1;

        // AES-128 unstalled timeline
        job(0, 0, 0, 0, 0, 0, tl, to, ti, pc, pr, po, pe);
        chk("t128_last", tl, 41); chk("t128_out", to, 45); chk("t128_idle", ti, 49);

        // key_valid low 3 cycles at round 5 beat 2
        job(0, 23, 0, 0, 0, 25, tl, to, ti, pc, pr, po, pe);
        chk("kstall_cnt", pc, 2); chk("kstall_round", pr, 5);
        chk("kstall_out", to, 48); chk("kstall_idle", ti, 52);

        // out_ready low 2 cycles at DONE beat 1
        job(0, 0, 46, 0, 0, 47, tl, to, ti, pc, pr, po, pe);
        chk("ostall_cnt", pc, 1); chk("ostall_ov", po, 1); chk("ostall_idle", ti, 51);

        // abort mid-ROUND
        job(0, 0, 0, 10, 0, 11, tl, to, ti, pc, pr, po, pe);
        chk("abort_idle", ti, 11); chk("abort_err", pe, 0);

        // reset during LAST, then a fresh AES-192 job
        job(0, 0, 0, 0, 42, 43, tl, to, ti, pc, pr, po, pe);
        chk("rst_last_idle", ti, 43); chk("rst_last_ov", po, 0); chk("rst_last_round", pr, 0);
        job(1, 0, 0, 0, 0, 0, tl, to, ti, pc, pr, po, pe);
        chk("t192_last", tl, 49); chk("t192_out", to, 53); chk("t192_idle", ti, 57);

        // reserved key length
        job(3, 0, 0, 0, 0, 1, tl, to, ti, pc, pr, po, pe);
        chk("kl3_err", pe, 1); chk("kl3_idle", ti, 1);

        // COLS=4, AES-256
        s4_start_valid = 1; s4_key_len = 2; s4_mode = 1;
        s4_din_valid = 1; s4_key_valid = 1; s4_out_ready = 1;
        en4 = 0; dn4 = 0; to4 = -1; ti4 = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            s4_start_valid = 0;
            if (out_valid4 && to4 < 0) to4 = n;
            if (idle_round4) begin
                ti4 = n;
                break;
            end
            @(negedge clk);
            if (round_en4) en4++;
            if (done_round4) dn4++;
        end
        chk("c4_round_en", en4, 15); chk("c4_done", dn4, 1);
        chk("c4_out", to4, 16); chk("c4_idle", ti4, 17);
        chk("c4_start_ready", start_ready4, 1); chk("c4_input", input_round4, 0);
        chk("c4_last", last_round4, 0); chk("c4_din_ready", din_ready4, 0);
        chk("c4_key_req", key_req4, 0); chk("c4_ov", out_valid4, 0);
        chk("c4_err", err4, 0); chk("c4_mode_q", mode_q4, 1);
        chk("c4_round_idx", round_idx4, 0); chk("c4_cnt", count_cycle4, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst         = ($urandom_range(0, 299) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            start_valid = ($urandom_range(0, 3) == 0);
            key_len     = 2'($urandom_range(0, 3));
            mode        = 1'($urandom_range(0, 1));
            din_valid   = ($urandom_range(0, 9) < 8);
            key_valid   = ($urandom_range(0, 9) < 8);
            out_ready   = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        rst = 0; abort = 0; start_valid = 0;
        @(posedge clk); #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter COLS, default 1, meaning 32-bit columns processed per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL derive B = 4/COLS beats per round and CNT_W = max(1, log2(B)).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start_valid / start_ready  in/out  1/1  job request handshake.
REQ-006 key_len  in  2  0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3=reserved.
REQ-007 mode  in  1  1=encrypt, 0=decrypt; captured at start and driven on mode_q (out, 1).
REQ-008 din_valid / din_ready  in/out  1/1  input-block beat handshake.
REQ-009 key_valid  in  1  round key for current beat present; key_req  out  1  round key requested.
REQ-010 out_valid / out_ready  out/in  1/1  result beat handshake.
REQ-011 abort  in  1  cancel current job.
REQ-012 count_cycle  out  CNT_W  beat index within round; round_idx  out  4  current round 0..Nr.
REQ-013 input_round, last_round, done_round, idle_round  out  1 each  datapath phase strobes.
REQ-014 round_en  out  1  datapath state register capture enable; err  out  1  one-cycle error pulse.

Function
REQ-015 States SHALL be IDLE, LOAD, ROUND, LAST, DONE.
REQ-016 IDLE: start_ready=1 and idle_round=1; on start_valid with key_len!=3, capture key_len and mode, clear counters, go to LOAD.
REQ-017 On start_valid with key_len=3 in IDLE: accept (start_ready=1), pulse err for 1 cycle, remain IDLE.
REQ-018 LOAD: round_idx=0, input_round=1, din_ready=1, key_req=1; a beat advances only when din_valid&key_valid, with round_en=1 on that cycle.
REQ-019 ROUND: round_idx 1..Nr-1, key_req=1; a beat advances on key_valid; round_en=key_valid.
REQ-020 LAST: round_idx=Nr, last_round=1; beat advance rule as ROUND.
REQ-021 A beat advance SHALL increment count_cycle; at count_cycle=B-1 it SHALL wrap to 0 and increment round_idx, moving LOAD->ROUND, ROUND->LAST when round_idx becomes Nr, and LAST->DONE.
REQ-022 DONE: done_round=1, out_valid=1, round_idx=Nr; beat advances on out_ready; after beat B-1 is accepted go to IDLE.
REQ-023 When no beat advances (stall), state, count_cycle and round_idx SHALL hold and round_en=0.
REQ-024 abort in any non-IDLE state SHALL force IDLE next cycle, clear counters, with no err; abort overrides any same-cycle handshake; abort in IDLE is ignored.
REQ-025 start_ready SHALL be 0 outside IDLE; back-to-back jobs incur one IDLE cycle.
REQ-026 Unstalled latency: start accept at cycle T; first out_valid at T+1+(Nr+1)*B (AES-128, COLS=1: T+45).
REQ-027 All strobes SHALL be registered-state decodes; no combinational path from out_ready, din_valid or key_valid to state outputs except round_en, din_ready and key_req qualification.

Reset
REQ-028 While rst=1 the block SHALL enter IDLE with count_cycle=0, round_idx=0, idle_round=1, start_ready=1, and all other outputs 0.
REQ-029 rst mid-job SHALL discard the job with no err and no out_valid.

Verification
REQ-030 COLS=1, key_len=0, key_valid and din_valid held 1: start at T -> LOAD T+1..T+4, LAST at T+41..T+44, out_valid T+45..T+48, idle_round at T+49.
REQ-031 COLS=4, key_len=2: exactly 15 round_en pulses; done_round for 1 cycle with out_ready=1.
REQ-032 key_valid low for 3 cycles in round 5, beat 2 -> count_cycle=2 and round_idx=5 held, round_en=0, completion delayed exactly 3 cycles.
REQ-033 key_len=3 start -> err high one cycle, idle_round stays 1, no din_ready.
REQ-034 out_ready low 2 cycles at DONE beat 1 -> out_valid held, count_cycle=1 held; abort during ROUND -> IDLE next cycle, err=0.
REQ-035 rst asserted in LAST -> next cycle all outputs at reset values; a new start is accepted.
